// File: rtl/crm_rst_seq.sv
// Reset sequencer for the clock-reset manager: soft_rst pulse, lock filter,
// staged subsystem reset release and lock-loss accounting.
module crm_rst_seq #(
  parameter logic [15:0] RST_WIDTH = 16'd1000,
  parameter logic [15:0] STAGE_GAP = 16'd125,
  parameter int          NUM_STAGE = 4,
  parameter logic [7:0]  LOCK_FILT = 8'd64
) (
  input  logic                 clk_125m,
  input  logic                 rst_125m_n,
  input  logic                 sw_rst_req,
  input  logic                 pll_lock_a,
  input  logic                 pll_lock_b,
  input  logic                 lock_lost_clr,
  output logic                 soft_rst,
  output logic [NUM_STAGE-1:0] stage_rst_n,
  output logic                 seq_busy,
  output logic [2:0]           seq_state,
  output logic [7:0]           lock_lost_cnt
);

  localparam logic [2:0] ST_ASSERT = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_REL    = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;

  localparam int TMR_MAX = (RST_WIDTH > STAGE_GAP) ?
                           int'(RST_WIDTH) : int'(STAGE_GAP);
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_WIDTH - 16'd1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(STAGE_GAP - 16'd1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGE - 1);

  logic                 r_lock_a_m;
  logic                 r_lock_a_s;
  logic                 r_lock_b_m;
  logic                 r_lock_b_s;
  logic [7:0]           r_filt;
  logic [7:0]           r_cnt;
  logic [2:0]           r_state;
  logic                 r_soft;
  logic                 r_busy;
  logic [NUM_STAGE-1:0] r_stage;
  logic [TMR_W-1:0]     r_tmr;
  logic [IDX_W-1:0]     r_idx;

  logic                 w_lock_ok;
  logic                 w_lock_stable;
  logic                 w_loss;
  logic [NUM_STAGE-1:0] w_stage_bit;

  assign w_lock_ok     = r_lock_a_s & r_lock_b_s;
  assign w_lock_stable = (r_filt == LOCK_FILT);
  assign w_loss        = ~w_lock_ok &
                         ((r_state == ST_REL) | (r_state == ST_RUN));
  assign w_stage_bit   = NUM_STAGE'(1) << r_idx;

  always_ff @(posedge clk_125m or negedge rst_125m_n) begin
    if (!rst_125m_n) begin
      r_lock_a_m <= 1'b0;
      r_lock_a_s <= 1'b0;
      r_lock_b_m <= 1'b0;
      r_lock_b_s <= 1'b0;
    end else begin
      r_lock_a_m <= pll_lock_a;
      r_lock_a_s <= r_lock_a_m;
      r_lock_b_m <= pll_lock_b;
      r_lock_b_s <= r_lock_b_m;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_125m_n) begin
    if (!rst_125m_n) begin
      r_filt <= 8'd0;
    end else if (!w_lock_ok) begin
      r_filt <= 8'd0;
    end else if (r_filt != LOCK_FILT) begin
      r_filt <= r_filt + 8'd1;
    end
  end

  // Clear has priority over a same-cycle loss event
  always_ff @(posedge clk_125m or negedge rst_125m_n) begin
    if (!rst_125m_n) begin
      r_cnt <= 8'd0;
    end else if (lock_lost_clr) begin
      r_cnt <= 8'd0;
    end else if (w_loss && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_125m_n) begin
    if (!rst_125m_n) begin
      r_state <= ST_WAIT;
      r_soft  <= 1'b1;
      r_busy  <= 1'b1;
      r_stage <= '0;
      r_tmr   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (r_tmr == RST_LAST) begin
            r_state <= ST_WAIT;
            r_soft  <= 1'b1;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_WAIT: begin
          if (sw_rst_req) begin
            r_state <= ST_ASSERT;
            r_soft  <= 1'b0;
            r_tmr   <= '0;
            r_stage <= '0;
          end else if (w_lock_stable) begin
            r_state <= ST_REL;
            r_tmr   <= '0;
            r_idx   <= '0;
          end
        end
        ST_REL, ST_RUN: begin
          if (sw_rst_req) begin
            r_state <= ST_ASSERT;
            r_soft  <= 1'b0;
            r_busy  <= 1'b1;
            r_tmr   <= '0;
            r_stage <= '0;
          end else if (!w_lock_ok) begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
            r_stage <= '0;
          end else if (r_state == ST_REL) begin
            if (r_tmr == GAP_LAST) begin
              r_tmr   <= '0;
              r_idx   <= r_idx + 1'b1;
              r_stage <= r_stage | w_stage_bit;
              if (r_idx == IDX_LAST) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_soft  <= 1'b1;
          r_busy  <= 1'b1;
          r_stage <= '0;
          r_tmr   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign soft_rst      = r_soft;
  assign stage_rst_n   = r_stage;
  assign seq_busy      = r_busy;
  assign seq_state     = r_state;
  assign lock_lost_cnt = r_cnt;

endmodule

// File: tb/tb_crm_rst_seq.sv
// Bench for crm_rst_seq: directed scenarios plus random lock/request traffic
// checked every cycle against a behavioural model.
module tb_crm_rst_seq;

  localparam int RW  = 20;
  localparam int GAP = 10;
  localparam int NS  = 4;
  localparam int LF  = 8;

  localparam int S_ASSERT = 0;
  localparam int S_WAIT   = 1;
  localparam int S_REL    = 2;
  localparam int S_RUN    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw;
  logic          la;
  logic          lb;
  logic          clr;
  logic          soft_rst;
  logic [NS-1:0] stage_rst_n;
  logic          seq_busy;
  logic [2:0]    seq_state;
  logic [7:0]    lock_lost_cnt;

  always #4 clk = ~clk;

  crm_rst_seq #(
    .RST_WIDTH(16'd20),
    .STAGE_GAP(16'd10),
    .NUM_STAGE(4),
    .LOCK_FILT(8'd8)
  ) u_dut (
    .clk_125m     (clk),
    .rst_125m_n   (rst_n),
    .sw_rst_req   (sw),
    .pll_lock_a   (la),
    .pll_lock_b   (lb),
    .lock_lost_clr(clr),
    .soft_rst     (soft_rst),
    .stage_rst_n  (stage_rst_n),
    .seq_busy     (seq_busy),
    .seq_state    (seq_state),
    .lock_lost_cnt(lock_lost_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model state
  int   m_st;
  int   m_filt;
  int   m_el;
  int   m_rc;
  int   m_cnt;
  int   m_stg;
  logic m_soft;
  logic m_busy;
  logic m_a1, m_a2, m_b1, m_b2;

  task automatic m_reset();
    m_st   = S_WAIT;
    m_filt = 0;
    m_el   = 0;
    m_rc   = 0;
    m_cnt  = 0;
    m_stg  = 0;
    m_soft = 1'b1;
    m_busy = 1'b1;
    m_a1 = 1'b0; m_a2 = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0;
  endtask

  task automatic m_step();
    logic ok;
    logic stable;
    logic active;
    ok     = m_a2 & m_b2;
    stable = (m_filt == LF);
    active = (m_st == S_REL) || (m_st == S_RUN);
    if (clr) m_cnt = 0;
    else if (!ok && active) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (m_st == S_ASSERT) begin
      m_el++;
      if (m_el == RW) begin
        m_st = S_WAIT;
        m_soft = 1'b1;
      end
    end else if (sw) begin
      m_st = S_ASSERT; m_el = 0; m_soft = 1'b0; m_stg = 0; m_busy = 1'b1;
    end else if (m_st == S_WAIT) begin
      if (stable) begin
        m_st = S_REL;
        m_rc = 0;
      end
    end else if (!ok) begin
      m_st = S_WAIT; m_stg = 0; m_busy = 1'b1;
    end else if (m_st == S_REL) begin
      m_rc++;
      m_stg = (1 << (m_rc / GAP)) - 1;
      if (m_rc == NS * GAP) begin
        m_st = S_RUN;
        m_busy = 1'b0;
      end
    end
    m_filt = ok ? ((m_filt < LF) ? m_filt + 1 : LF) : 0;
    m_a2 = m_a1; m_a1 = la;
    m_b2 = m_b1; m_b1 = lb;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".soft"},  32'(soft_rst),      32'(m_soft));
    chk({tag, ".stage"}, 32'(stage_rst_n),   32'(m_stg));
    chk({tag, ".busy"},  32'(seq_busy),      32'(m_busy));
    chk({tag, ".state"}, 32'(seq_state),     32'(m_st));
    chk({tag, ".cnt"},   32'(lock_lost_cnt), 32'(m_cnt));
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1 check_all("cyc");
  endtask

  task automatic wait_st(input int s, input string tag);
    int n;
    n = 0;
    while (m_st != s && n < 400) begin
      cyc();
      n++;
    end
    chk(tag, 32'(m_st), 32'(s));
  endtask

  int lo;

  initial begin
    rst_n = 1'b0; sw = 1'b0; clr = 1'b0; la = 1'b1; lb = 1'b1;
    m_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // locks high from reset release
    repeat (70) cyc();
    chk("boot_stage", 32'(stage_rst_n), 32'hF);
    chk("boot_busy",  32'(seq_busy),    32'd0);
    chk("boot_cnt",   32'(lock_lost_cnt), 32'd0);

    // soft reset request in RUN
    lo = 0;
    for (int i = 0; i < 80; i++) begin
      sw = (i == 0);
      cyc();
      if (soft_rst === 1'b0) lo++;
    end
    sw = 1'b0;
    chk("sw_width", 32'(lo), 32'(RW));

    // one-cycle lock_b drop in RUN
    lb = 1'b0;
    cyc();
    lb = 1'b1;
    repeat (70) cyc();
    chk("loss_cnt", 32'(lock_lost_cnt), 32'd1);

    // glitch during the filter window
    la = 1'b0; cyc(); la = 1'b1;
    repeat (7) cyc();
    la = 1'b0; cyc(); la = 1'b1;
    repeat (8) cyc();
    chk("glitch_hold", 32'(stage_rst_n), 32'd0);
    repeat (70) cyc();

    // second request while ASSERT is running
    lo = 0;
    for (int i = 0; i < 90; i++) begin
      sw = (i == 0 || i == 6);
      cyc();
      if (soft_rst === 1'b0) lo++;
    end
    sw = 1'b0;
    chk("sw_ignored_width", 32'(lo), 32'(RW));

    // request coincident with a lock loss in RUN
    wait_st(S_RUN, "to_run");
    lb = 1'b0;
    cyc(); cyc();
    lo = m_cnt;
    sw = 1'b1; lb = 1'b1;
    cyc();
    sw = 1'b0;
    chk("sw_loss_state", 32'(seq_state), 32'(S_ASSERT));
    chk("sw_loss_cnt", 32'(lock_lost_cnt), 32'(lo + 1));

    // saturate the loss counter
    for (int k = 0; k < 260; k++) begin
      wait_st(S_REL, "sat_rel");
      la = 1'b0; cyc(); la = 1'b1;
      repeat (3) cyc();
    end
    chk("sat_cnt", 32'(lock_lost_cnt), 32'd255);

    // clear in the same cycle as a counted loss
    wait_st(S_REL, "clr_rel");
    lb = 1'b0;
    lo = 0;
    while (!(!(m_a2 & m_b2) && (m_st == S_REL || m_st == S_RUN)) && lo < 10) begin
      cyc();
      lo++;
    end
    clr = 1'b1; lb = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_wins", 32'(lock_lost_cnt), 32'd0);

    // async reset in the middle of the staged release
    wait_st(S_REL, "arst_rel");
    while (m_stg == 0 && m_st == S_REL) cyc();
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) cyc();
    chk("arst_run", 32'(seq_state), 32'(S_RUN));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      la  = ($urandom % 300) != 0;
      lb  = ($urandom % 300) != 0;
      sw  = ($urandom % 200) == 0;
      clr = ($urandom % 400) == 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
